// File: rtl/ghffe_pkg.sv
// Shared types and defaults for the FFT-board note frame receiver.
package ghffe_pkg;

   // Serial receiver states: wait for sync edge, shift data bits, take parity bit
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } rx_state_t;

   localparam int NOTE_W_DEFAULT     = 37;
   localparam int FRAME_BITS_DEFAULT = 48;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/note_autoplay_walker.sv
// Rate-controlled walking-one generator used for the autoplay demo mode.
// The single set bit walks upward; after the MSB falls off there is one
// all-zero step before the pattern restarts at bit 0.
module note_autoplay_walker
   import ghffe_pkg::*;
#(
   parameter int NOTE_W      = NOTE_W_DEFAULT,
   parameter int STEP_CYCLES = 1
)(
   input  logic              clk,
   input  logic              srst,
   input  logic              i_enable,
   input  logic              i_clear,
   output logic [NOTE_W-1:0] o_notes,
   output logic              o_step
);

   localparam int SW = cnt_width(STEP_CYCLES);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

   logic [SW-1:0]     r_step;
   logic [NOTE_W-1:0] r_notes;
   logic              r_step_pulse;

   // Step timer and walking-one register; a clear restarts the pattern from zero
   always_ff @(posedge clk) begin
      if (srst) begin
         r_step       <= '0;
         r_notes      <= '0;
         r_step_pulse <= 1'b0;
      end else begin
         r_step_pulse <= 1'b0;
         if (i_clear) begin
            r_step  <= '0;
            r_notes <= '0;
         end else if (i_enable) begin
            if (r_step == STEP_LAST) begin
               r_step       <= '0;
               r_notes      <= (r_notes == '0) ? NOTE_W'(1) : (r_notes << 1);
               r_step_pulse <= 1'b1;
            end else begin
               r_step <= r_step + 1'b1;
            end
         end
      end
   end

   assign o_notes = r_notes;
   assign o_step  = r_step_pulse;

endmodule

// File: rtl/note_frame_receiver.sv
// Framed, even-parity serial note receiver with stale detection, error
// counting and an autoplay (walking-one) mode for the scoring block.
module note_frame_receiver
   import ghffe_pkg::*;
#(
   parameter int FRAME_BITS     = FRAME_BITS_DEFAULT,
   parameter int NOTE_W         = NOTE_W_DEFAULT,
   parameter int BIT_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 10_000_000,
   parameter int STEP_CYCLES    = 1,
   parameter int LIVE_SHIFT     = 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  serial_sync,
   input  logic                  serial_data,
   input  logic                  autoplay,
   output logic [NOTE_W-1:0]     notes,
   output logic                  notes_valid,
   output logic [FRAME_BITS-1:0] active_raw,
   output logic                  frame_err,
   output logic [7:0]            err_count,
   output logic                  stale
);

   localparam int PW = cnt_width(BIT_CYCLES);
   localparam int IW = cnt_width(FRAME_BITS);
   localparam int TW = cnt_width(TIMEOUT_CYCLES);

   localparam logic [PW-1:0] PHASE_HALF = PW'(BIT_CYCLES / 2 - 1);
   localparam logic [PW-1:0] PHASE_FULL = PW'(BIT_CYCLES - 1);
   localparam logic [IW-1:0] BIT_LAST   = IW'(FRAME_BITS - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_PRE     = TW'(TIMEOUT_CYCLES - 2);

   rx_state_t             r_state;
   rx_state_t             w_state_next;
   logic                  r_sync_d;
   logic [PW-1:0]         r_phase;
   logic [IW-1:0]         r_bit_idx;
   logic [FRAME_BITS-1:0] r_shreg;
   logic [FRAME_BITS-1:0] r_active_raw;
   logic                  r_frame_err;
   logic [7:0]            r_err_count;
   logic                  r_autoplay_d;
   logic [NOTE_W-1:0]     r_live_notes;
   logic                  r_live_valid;
   logic [TW-1:0]         r_to;
   logic                  r_stale;

   logic                  w_sync_rise;
   logic                  w_sample;
   logic                  w_abort;
   logic                  w_par_check;
   logic                  w_parity_ok;
   logic                  w_commit;
   logic                  w_err;
   logic                  w_toggle;
   logic [NOTE_W-1:0]     w_mapped;
   logic [NOTE_W-1:0]     w_walk_notes;
   logic                  w_walk_step;

   // Receiver state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Receiver next-state: a dropped sync at any sample point aborts to IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:   if (w_sync_rise) w_state_next = SHIFT;
         SHIFT:  if (w_sample) begin
                    if (!serial_sync)             w_state_next = IDLE;
                    else if (r_bit_idx == BIT_LAST) w_state_next = PARITY;
                 end
         PARITY: if (w_sample) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Receiver decode: sample strobes, abort, parity verdict
   always_comb begin
      w_sync_rise = (r_state == IDLE) && !r_sync_d && serial_sync;
      w_sample    = (r_state != IDLE) && (r_phase == '0);
      w_abort     = w_sample && !serial_sync;
      w_par_check = (r_state == PARITY) && w_sample && serial_sync;
      w_parity_ok = ~((^r_shreg) ^ serial_data);
      w_commit    = w_par_check && w_parity_ok;
      w_err       = w_abort || (w_par_check && !w_parity_ok);
   end

   // Bit timing and shift register; the first sample lands mid-bit and ends up in the MSB
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_d  <= 1'b0;
         r_phase   <= '0;
         r_bit_idx <= '0;
         r_shreg   <= '0;
      end else begin
         r_sync_d <= serial_sync;
         if (w_sync_rise) begin
            r_phase   <= PHASE_HALF;
            r_bit_idx <= '0;
         end else if (r_state != IDLE) begin
            if (r_phase == '0) begin
               r_phase <= PHASE_FULL;
               if (r_state == SHIFT) begin
                  r_shreg   <= {r_shreg[FRAME_BITS-2:0], serial_data};
                  r_bit_idx <= r_bit_idx + 1'b1;
               end
            end else begin
               r_phase <= r_phase - 1'b1;
            end
         end
      end
   end

   // Frame bookkeeping: last good frame and saturating error count, independent of mode
   always_ff @(posedge clk) begin
      if (reset) begin
         r_active_raw <= '0;
         r_frame_err  <= 1'b0;
         r_err_count  <= '0;
      end else begin
         r_frame_err <= w_err;
         if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
         if (w_commit) r_active_raw <= r_shreg;
      end
   end

   generate
      if (LIVE_SHIFT != 0) begin : g_live_shift
         assign w_mapped = {r_shreg[NOTE_W-2:0], 1'b0};
      end else begin : g_live_direct
         assign w_mapped = r_shreg[NOTE_W-1:0];
      end
   endgenerate

   assign w_toggle = autoplay ^ r_autoplay_d;

   // Live-mode notes and stale timer; a mode toggle clears notes ahead of any commit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_autoplay_d <= 1'b0;
         r_live_notes <= '0;
         r_live_valid <= 1'b0;
         r_to         <= '0;
         r_stale      <= 1'b0;
      end else begin
         r_autoplay_d <= autoplay;
         r_live_valid <= 1'b0;
         if (autoplay) begin
            r_to    <= '0;
            r_stale <= 1'b0;
            if (w_toggle) r_live_notes <= '0;
         end else begin
            if (w_commit) begin
               r_to    <= '0;
               r_stale <= 1'b0;
            end else if (r_to != TO_LAST) begin
               r_to <= r_to + 1'b1;
               if (r_to == TO_PRE) r_stale <= 1'b1;
            end
            if (w_toggle) begin
               r_live_notes <= '0;
            end else if (w_commit) begin
               r_live_notes <= w_mapped;
               r_live_valid <= 1'b1;
            end else if (r_to == TO_PRE) begin
               r_live_notes <= '0;
               r_live_valid <= 1'b1;
            end
         end
      end
   end

   note_autoplay_walker #(
      .NOTE_W      (NOTE_W),
      .STEP_CYCLES (STEP_CYCLES)
   ) u_walker (
      .clk      (clk),
      .srst     (reset),
      .i_enable (autoplay),
      .i_clear  (w_toggle),
      .o_notes  (w_walk_notes),
      .o_step   (w_walk_step)
   );

   // Both note sources are zeroed on a toggle, so switching on the registered mode is glitch-free
   assign notes       = r_autoplay_d ? w_walk_notes : r_live_notes;
   assign notes_valid = r_autoplay_d ? w_walk_step  : r_live_valid;
   assign active_raw  = r_active_raw;
   assign frame_err   = r_frame_err;
   assign err_count   = r_err_count;
   assign stale       = r_stale;

endmodule

// File: tb/tb_note_frame_receiver.sv
// Self-checking bench for note_frame_receiver (8-bit frames, 4 clocks per bit).
module tb_note_frame_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic       serial_sync;
   logic       serial_data;
   logic       autoplay;
   logic [7:0] notes;
   logic       notes_valid;
   logic [7:0] active_raw;
   logic       frame_err;
   logic [7:0] err_count;
   logic       stale;

   int total = 0;
   int bad   = 0;
   int nv_cnt = 0;
   int fe_cnt = 0;

   // reference model state
   logic [7:0] m_raw;
   logic [7:0] m_notes;
   int         m_err;

   note_frame_receiver #(
      .FRAME_BITS     (8),
      .NOTE_W         (8),
      .BIT_CYCLES     (4),
      .TIMEOUT_CYCLES (100),
      .STEP_CYCLES    (1),
      .LIVE_SHIFT     (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .serial_sync (serial_sync),
      .serial_data (serial_data),
      .autoplay    (autoplay),
      .notes       (notes),
      .notes_valid (notes_valid),
      .active_raw  (active_raw),
      .frame_err   (frame_err),
      .err_count   (err_count),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   // pulse counters, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         if (notes_valid) nv_cnt++;
         if (frame_err)   fe_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] live_map(input logic [7:0] d);
      return {d[6:0], 1'b0};
   endfunction

   // Sends MSB-first data then parity, each bit held 4 clocks; abort_bit>=0 drops sync for that bit
   task automatic send_frame(input logic [7:0] d, input logic p, input int abort_bit, input int gap);
      serial_sync = 1'b1;
      for (int b = 0; b < 9; b++) begin
         serial_data = (b < 8) ? d[7-b] : p;
         if (b == abort_bit) serial_sync = 1'b0;
         repeat (4) tick();
         if (b == abort_bit) break;
      end
      serial_sync = 1'b0;
      serial_data = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic check_all_zero(input string tag);
      total++; if (notes !== 8'h00) begin bad++; $display("FAIL %s notes got=%h want=00", tag, notes); end
      total++; if (notes_valid !== 1'b0) begin bad++; $display("FAIL %s notes_valid got=%b want=0", tag, notes_valid); end
      total++; if (active_raw !== 8'h00) begin bad++; $display("FAIL %s active_raw got=%h want=00", tag, active_raw); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL %s frame_err got=%b want=0", tag, frame_err); end
      total++; if (err_count !== 8'h00) begin bad++; $display("FAIL %s err_count got=%0d want=0", tag, err_count); end
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL %s stale got=%b want=0", tag, stale); end
   endtask

   task automatic test_reset();
      reset = 1'b1; serial_sync = 1'b0; serial_data = 1'b0; autoplay = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_all_zero("reset");
      m_raw = 8'h00; m_notes = 8'h00; m_err = 0;
      $display("reset: outputs checked");
   endtask

   task automatic test_good_frame();
      int nv0, fe0;
      nv0 = nv_cnt; fe0 = fe_cnt;
      send_frame(8'hA5, 1'b0, -1, 4);
      m_raw = 8'hA5; m_notes = live_map(8'hA5);
      total++; if (active_raw !== m_raw) begin bad++; $display("FAIL good_raw got=%h want=%h", active_raw, m_raw); end
      total++; if (notes !== m_notes) begin bad++; $display("FAIL good_notes got=%h want=%h", notes, m_notes); end
      total++; if (nv_cnt - nv0 !== 1) begin bad++; $display("FAIL good_valid_pulses got=%0d want=1", nv_cnt - nv0); end
      total++; if (err_count !== 8'd0) begin bad++; $display("FAIL good_err got=%0d want=0", err_count); end
      total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL good_frame_err got=%0d want=0", fe_cnt - fe0); end
      $display("frame A5 p0: raw=%h notes=%h", active_raw, notes);
   endtask

   task automatic test_bad_parity();
      int nv0, fe0;
      nv0 = nv_cnt; fe0 = fe_cnt;
      send_frame(8'h01, 1'b0, -1, 4);
      m_err++;
      total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL parity_err_pulse got=%0d want=1", fe_cnt - fe0); end
      total++; if (err_count !== 8'(m_err)) begin bad++; $display("FAIL parity_err_count got=%0d want=%0d", err_count, m_err); end
      total++; if (notes !== m_notes) begin bad++; $display("FAIL parity_notes_hold got=%h want=%h", notes, m_notes); end
      total++; if (active_raw !== m_raw) begin bad++; $display("FAIL parity_raw_hold got=%h want=%h", active_raw, m_raw); end
      total++; if (nv_cnt - nv0 !== 0) begin bad++; $display("FAIL parity_no_valid got=%0d want=0", nv_cnt - nv0); end
      $display("frame 01 p0 (bad): err_count=%0d", err_count);
   endtask

   task automatic test_abort();
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'hFF, 1'b0, 3, 4);
      m_err++;
      total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL abort_pulse got=%0d want=1", fe_cnt - fe0); end
      total++; if (err_count !== 8'(m_err)) begin bad++; $display("FAIL abort_err_count got=%0d want=%0d", err_count, m_err); end
      send_frame(8'h3C, 1'b0, -1, 3);
      m_raw = 8'h3C; m_notes = live_map(8'h3C);
      total++; if (notes !== m_notes) begin bad++; $display("FAIL abort_next_notes got=%h want=%h", notes, m_notes); end
      total++; if (active_raw !== m_raw) begin bad++; $display("FAIL abort_next_raw got=%h want=%h", active_raw, m_raw); end
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL abort_next_stale got=%b want=0", stale); end
      $display("abort then frame 3C: notes=%h err_count=%0d", notes, err_count);
   endtask

   task automatic test_random_frames();
      logic [7:0] d;
      logic       p;
      logic       is_bad;
      logic       prev_bad;
      int         nv0, fe0;
      prev_bad = 1'b0;
      for (int i = 0; i < 14; i++) begin
         d = 8'($urandom);
         is_bad = prev_bad ? 1'b0 : ($urandom_range(0, 2) == 0);
         p = is_bad ? ~(^d) : (^d);
         nv0 = nv_cnt; fe0 = fe_cnt;
         send_frame(d, p, -1, $urandom_range(2, 8));
         if (is_bad) m_err++;
         else begin
            m_raw = d;
            m_notes = live_map(d);
         end
         total++; if (active_raw !== m_raw) begin bad++; $display("FAIL rnd%0d raw got=%h want=%h", i, active_raw, m_raw); end
         total++; if (notes !== m_notes) begin bad++; $display("FAIL rnd%0d notes got=%h want=%h", i, notes, m_notes); end
         total++; if (err_count !== 8'(m_err)) begin bad++; $display("FAIL rnd%0d err got=%0d want=%0d", i, err_count, m_err); end
         total++; if (nv_cnt - nv0 !== (is_bad ? 0 : 1)) begin bad++; $display("FAIL rnd%0d valid got=%0d want=%0d", i, nv_cnt - nv0, is_bad ? 0 : 1); end
         total++; if (fe_cnt - fe0 !== (is_bad ? 1 : 0)) begin bad++; $display("FAIL rnd%0d ferr got=%0d want=%0d", i, fe_cnt - fe0, is_bad ? 1 : 0); end
         $display("rnd frame %0d: data=%h parity=%b bad=%b notes=%h", i, d, p, is_bad, notes);
         prev_bad = is_bad;
      end
   endtask

   task automatic test_autoplay();
      logic [7:0] exp;
      int pos;
      autoplay = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (k == 1) exp = 8'h00;
         else begin
            pos = (k - 2) % 9;
            exp = (pos < 8) ? 8'(1 << pos) : 8'h00;
         end
         total++; if (notes !== exp) begin bad++; $display("FAIL auto_step%0d notes got=%h want=%h", k, notes, exp); end
         if (k >= 2) begin
            total++; if (notes_valid !== 1'b1) begin bad++; $display("FAIL auto_step%0d valid got=%b want=1", k, notes_valid); end
         end
      end
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL auto_stale got=%b want=0", stale); end
      autoplay = 1'b0;
      tick();
      m_notes = 8'h00;
      total++; if (notes !== 8'h00) begin bad++; $display("FAIL auto_exit_notes got=%h want=00", notes); end
      $display("autoplay: 22 steps walked, exit notes=%h", notes);
      repeat (2) tick();
   endtask

   task automatic test_stale();
      int nv0;
      send_frame(8'h66, 1'b0, -1, 0);
      m_raw = 8'h66; m_notes = live_map(8'h66);
      total++; if (notes !== m_notes) begin bad++; $display("FAIL stale_pre_notes got=%h want=%h", notes, m_notes); end
      nv0 = nv_cnt;
      repeat (89) tick();
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_early got=%b want=0", stale); end
      total++; if (nv_cnt - nv0 !== 0) begin bad++; $display("FAIL stale_early_valid got=%0d want=0", nv_cnt - nv0); end
      repeat (20) tick();
      total++; if (stale !== 1'b1) begin bad++; $display("FAIL stale_set got=%b want=1", stale); end
      total++; if (notes !== 8'h00) begin bad++; $display("FAIL stale_notes got=%h want=00", notes); end
      total++; if (nv_cnt - nv0 !== 1) begin bad++; $display("FAIL stale_valid got=%0d want=1", nv_cnt - nv0); end
      send_frame(8'h81, 1'b0, -1, 2);
      m_raw = 8'h81; m_notes = live_map(8'h81);
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL stale_clear got=%b want=0", stale); end
      total++; if (notes !== 8'h02) begin bad++; $display("FAIL stale_recover_notes got=%h want=02", notes); end
      total++; if (active_raw !== m_raw) begin bad++; $display("FAIL stale_recover_raw got=%h want=%h", active_raw, m_raw); end
      $display("stale: recovered with 81, notes=%h", notes);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      d = 8'hC3;
      serial_sync = 1'b1;
      for (int b = 0; b < 4; b++) begin
         serial_data = d[7-b];
         repeat (4) tick();
      end
      serial_data = d[3];
      repeat (2) tick();
      reset = 1'b1; serial_sync = 1'b0; serial_data = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check_all_zero("midreset");
      m_raw = 8'h00; m_notes = 8'h00; m_err = 0;
      send_frame(8'h3C, 1'b0, -1, 3);
      m_raw = 8'h3C; m_notes = live_map(8'h3C);
      total++; if (active_raw !== m_raw) begin bad++; $display("FAIL midreset_raw got=%h want=%h", active_raw, m_raw); end
      total++; if (notes !== m_notes) begin bad++; $display("FAIL midreset_notes got=%h want=%h", notes, m_notes); end
      total++; if (err_count !== 8'd0) begin bad++; $display("FAIL midreset_err got=%0d want=0", err_count); end
      $display("reset mid-frame: next frame 3C notes=%h", notes);
   endtask

   task automatic test_err_saturate();
      logic [7:0] d;
      for (int i = 0; i < 300; i++) begin
         d = 8'($urandom);
         send_frame(d, ~(^d), -1, 1);
         if (m_err < 255) m_err++;
         if (i + 1 == 254) begin
            total++; if (err_count !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", err_count); end
         end
         if (i + 1 == 255) begin
            total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", err_count); end
         end
      end
      total++; if (err_count !== 8'(m_err)) begin bad++; $display("FAIL sat_300 got=%0d want=%0d", err_count, m_err); end
      total++; if (active_raw !== m_raw) begin bad++; $display("FAIL sat_raw_hold got=%h want=%h", active_raw, m_raw); end
      $display("300 bad frames: err_count=%0d", err_count);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_parity();
      test_abort();
      test_random_frames();
      test_autoplay();
      test_stale();
      test_reset_midframe();
      test_err_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
